// File: rtl/risc8_uart_pkg.sv
// risc8 UART shared definitions: IO register map, UCSRA bit layout, RX FSM states.
// The SoC decode and firmware headers take their addresses from here so there is one source.
package risc8_uart_pkg;

    localparam logic [6:0] UART_ADDR_UDR   = 7'h2C;
    localparam logic [6:0] UART_ADDR_UCSRA = 7'h2B;
    localparam logic [6:0] UART_ADDR_UBRR  = 7'h29;

    localparam int UART_OVERSAMPLE = 16;

    localparam int UCSRA_RXC   = 7;
    localparam int UCSRA_TXC   = 6;
    localparam int UCSRA_UDRE  = 5;
    localparam int UCSRA_FE    = 4;
    localparam int UCSRA_DOR   = 3;
    localparam int UCSRA_RXCIE = 1;
    localparam int UCSRA_UDRIE = 0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Assemble the UCSRA read image; bit 2 is unimplemented and reads as zero.
    function automatic logic [7:0] pack_ucsra(input logic rxc, input logic txc,
                                              input logic udre, input logic fe,
                                              input logic dor, input logic rxcie,
                                              input logic udrie);
        return {rxc, txc, udre, fe, dor, 1'b0, rxcie, udrie};
    endfunction

endpackage

// File: rtl/risc8_uart_rx.sv
// risc8 UART receiver: two-flop synchroniser on rx plus the oversampled 8N1 frame FSM.
// Emits a one-cycle done pulse with the assembled byte and the stop-bit framing status.
module risc8_uart_rx
    import risc8_uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err
);

    localparam int                 PHASE_W    = $clog2(OVERSAMPLE);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [PHASE_W-1:0] PHASE_MID  = PHASE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

    rx_state_t          state;
    logic               rx_s1;
    logic               rx_s2;
    logic               rx_prev;
    logic [PHASE_W-1:0] phase;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;

    // Synchronise rx, detect the start edge, then sample mid-bit on baud ticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            done    <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state <= RX_START;
                        phase <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (phase == PHASE_MID) begin
                            phase   <= '0;
                            bit_cnt <= '0;
                            state   <= rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            phase <= phase + PHASE_ONE;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (phase == PHASE_LAST) begin
                            phase   <= '0;
                            shift   <= {rx_s2, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= RX_STOP;
                            end
                        end else begin
                            phase <= phase + PHASE_ONE;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (phase == PHASE_LAST) begin
                            phase     <= '0;
                            data      <= shift;
                            frame_err <= !rx_s2;
                            done      <= 1'b1;
                            state     <= RX_IDLE;
                        end else begin
                            phase <= phase + PHASE_ONE;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/risc8_uart.sv
// risc8 UART peripheral: IO bus decode, UDR/UCSRA/UBRR registers, baud generator,
// TX holding register plus shifter, and the interrupt level. Receive lives in risc8_uart_rx.
module risc8_uart
    import risc8_uart_pkg::*;
#(
    parameter logic [6:0] ADDR_UDR   = UART_ADDR_UDR,
    parameter logic [6:0] ADDR_UCSRA = UART_ADDR_UCSRA,
    parameter logic [6:0] ADDR_UBRR  = UART_ADDR_UBRR,
    parameter int         OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] io_addr,
    input  logic       io_wen,
    input  logic       io_ren,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_hit,
    output logic       tx,
    input  logic       rx,
    output logic       irq
);

    localparam int                 PHASE_W    = $clog2(OVERSAMPLE);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

    logic [7:0]         ubrr;
    logic [7:0]         baud_cnt;
    logic               tick;
    logic [7:0]         udr_rx;
    logic               rxc, txc, udre, fe, dor, rxcie, udrie;
    logic [7:0]         tx_hold;
    logic [7:0]         tx_shift;
    logic               tx_busy;
    logic [3:0]         tx_bit;
    logic [PHASE_W-1:0] tx_phase;
    logic [7:0]         rx_byte;
    logic               rx_done;
    logic               rx_ferr;

    logic sel_udr, sel_ucsra, sel_ubrr;
    logic wr_udr, wr_ucsra, wr_ubrr, rd_udr;

    assign sel_udr   = (io_addr == ADDR_UDR);
    assign sel_ucsra = (io_addr == ADDR_UCSRA);
    assign sel_ubrr  = (io_addr == ADDR_UBRR);
    assign wr_udr    = io_wen && sel_udr;
    assign wr_ucsra  = io_wen && sel_ucsra;
    assign wr_ubrr   = io_wen && sel_ubrr;
    assign rd_udr    = io_ren && sel_udr;

    assign tick = (baud_cnt == 8'd0);
    assign irq  = (rxc & rxcie) | (udre & udrie);

    // Baud divisor: count down from UBRR, tick on zero; a UBRR write restarts the period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ubrr     <= '0;
            baud_cnt <= '0;
        end else if (wr_ubrr) begin
            ubrr     <= io_wdata;
            baud_cnt <= io_wdata;
        end else if (tick) begin
            baud_cnt <= ubrr;
        end else begin
            baud_cnt <= baud_cnt - 8'd1;
        end
    end

    // Registered read port; samples register state before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            io_rdata <= '0;
            io_hit   <= 1'b0;
        end else begin
            io_hit <= io_ren && (sel_udr || sel_ucsra || sel_ubrr);
            if (io_ren && sel_udr) begin
                io_rdata <= udr_rx;
            end else if (io_ren && sel_ucsra) begin
                io_rdata <= pack_ucsra(rxc, txc, udre, fe, dor, rxcie, udrie);
            end else if (io_ren && sel_ubrr) begin
                io_rdata <= ubrr;
            end else begin
                io_rdata <= '0;
            end
        end
    end

    // Interrupt enable bits are the only plain read/write fields of UCSRA.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxcie <= 1'b0;
            udrie <= 1'b0;
        end else if (wr_ucsra) begin
            rxcie <= io_wdata[UCSRA_RXCIE];
            udrie <= io_wdata[UCSRA_UDRIE];
        end
    end

    // TX path: holding register feeds the shifter on a tick; a full holding register at
    // the end of the stop bit reloads immediately so consecutive frames have no idle gap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_bit   <= '0;
            tx_phase <= '0;
            tx_shift <= '0;
            tx_hold  <= '0;
            udre     <= 1'b1;
            txc      <= 1'b0;
        end else begin
            if (wr_ucsra && io_wdata[UCSRA_TXC]) begin
                txc <= 1'b0;
            end
            if (wr_udr && udre) begin
                tx_hold <= io_wdata;
                udre    <= 1'b0;
            end
            if (tick) begin
                if (!tx_busy) begin
                    if (!udre) begin
                        tx_busy  <= 1'b1;
                        tx_shift <= tx_hold;
                        tx_bit   <= '0;
                        tx_phase <= '0;
                        tx       <= 1'b0;
                        udre     <= 1'b1;
                    end
                end else if (tx_phase == PHASE_LAST) begin
                    tx_phase <= '0;
                    if (tx_bit == 4'd9) begin
                        if (!udre) begin
                            tx_shift <= tx_hold;
                            tx_bit   <= '0;
                            tx       <= 1'b0;
                            udre     <= 1'b1;
                        end else begin
                            tx_busy <= 1'b0;
                            tx      <= 1'b1;
                            txc     <= 1'b1;
                        end
                    end else begin
                        tx_bit   <= tx_bit + 4'd1;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[7:1]};
                    end
                end else begin
                    tx_phase <= tx_phase + PHASE_ONE;
                end
            end
        end
    end

    // RX flags: a finished frame lands in UDR unless an unread byte is waiting (overrun);
    // a UDR read in the same cycle frees the slot so the new byte is kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            udr_rx <= '0;
            rxc    <= 1'b0;
            fe     <= 1'b0;
            dor    <= 1'b0;
        end else if (rx_done) begin
            fe <= rx_ferr;
            if (!rxc || rd_udr) begin
                udr_rx <= rx_byte;
                rxc    <= 1'b1;
                if (rd_udr) begin
                    dor <= 1'b0;
                end
            end else begin
                dor <= 1'b1;
            end
        end else if (rd_udr) begin
            rxc <= 1'b0;
            dor <= 1'b0;
        end
    end

    risc8_uart_rx #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .rx       (rx),
        .data     (rx_byte),
        .done     (rx_done),
        .frame_err(rx_ferr)
    );

endmodule

// File: tb/tb_risc8_uart.sv
// Directed testbench for risc8_uart: reset, bus decode, TX framing, back-to-back TX,
// interrupts, RX, RX error cases and reset in the middle of traffic.
module tb_risc8_uart;

    localparam logic [6:0] A_UDR   = 7'h2C;
    localparam logic [6:0] A_UCSRA = 7'h2B;
    localparam logic [6:0] A_UBRR  = 7'h29;

    logic       clk;
    logic       reset;
    logic [6:0] io_addr;
    logic       io_wen;
    logic       io_ren;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_hit;
    logic       tx;
    logic       rx;
    logic       irq;

    int compared;
    int mismatched;

    logic logging;
    logic tx_log[$];

    risc8_uart dut (
        .clk     (clk),
        .reset   (reset),
        .io_addr (io_addr),
        .io_wen  (io_wen),
        .io_ren  (io_ren),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .io_hit  (io_hit),
        .tx      (tx),
        .rx      (rx),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the serial line once per clock so frame timing can be checked afterwards.
    always @(negedge clk) begin
        if (logging) tx_log.push_back(tx);
    end

    task automatic bus_write(input logic [6:0] addr, input logic [7:0] data);
        @(negedge clk);
        io_addr  = addr;
        io_wdata = data;
        io_wen   = 1'b1;
        @(negedge clk);
        io_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] addr, output logic [7:0] data, output logic hit);
        @(negedge clk);
        io_addr = addr;
        io_ren  = 1'b1;
        @(negedge clk);
        io_ren = 1'b0;
        data   = io_rdata;
        hit    = io_hit;
    endtask

    task automatic send_rx_frame(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (64) @(negedge clk);
        end
        rx = stop_bit;
        repeat (64) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       h;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (tx !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_tx: got %b expected 1", tx);
        end
        compared++;
        if (irq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        compared++;
        if (io_hit !== 1'b0 || io_rdata !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_bus: got hit=%b rdata=%h expected hit=0 rdata=00", io_hit, io_rdata);
        end
        reset = 1'b1;
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h20 || h !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_ucsra: got %h hit=%b expected 20 hit=1", d, h);
        end
        bus_read(A_UBRR, d, h);
        compared++;
        if (d !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_ubrr: got %h expected 00", d);
        end
    endtask

    task automatic test_bus();
        logic [7:0] d;
        logic       h;
        @(negedge clk);
        io_addr  = A_UBRR;
        io_wdata = 8'h07;
        io_wen   = 1'b1;
        io_ren   = 1'b1;
        @(negedge clk);
        io_wen = 1'b0;
        io_ren = 1'b0;
        compared++;
        if (io_rdata !== 8'h00 || io_hit !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_rw: got %h hit=%b expected 00 hit=1", io_rdata, io_hit);
        end
        bus_read(A_UBRR, d, h);
        compared++;
        if (d !== 8'h07) begin
            mismatched++;
            $display("[TB] FAIL ubrr_readback: got %h expected 07", d);
        end
        bus_read(7'h2A, d, h);
        compared++;
        if (h !== 1'b0 || d !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL unmapped_read: got %h hit=%b expected 00 hit=0", d, h);
        end
        bus_write(A_UBRR, 8'h00);
    endtask

    task automatic test_tx();
        logic [7:0] d;
        logic       h;
        logic [9:0] exp_bits;
        int         f;
        int         idx;
        int         run;
        logic       got;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        tx_log.delete();
        logging = 1'b1;
        bus_write(A_UDR, 8'hA5);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h20) begin
            mismatched++;
            $display("[TB] FAIL tx_udre_after_load: got %h expected 20", d);
        end
        repeat (200) @(negedge clk);
        logging = 1'b0;
        f = -1;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (f < 0 && tx_log[i] === 1'b0) f = i;
        end
        compared++;
        if (f < 0) begin
            mismatched++;
            $display("[TB] FAIL tx_start_seen: got none expected start bit");
        end else begin
            run = 0;
            while (f + run < tx_log.size() && tx_log[f + run] === 1'b0) run++;
            if (run != 16) begin
                mismatched++;
                $display("[TB] FAIL tx_start_width: got %0d clk expected 16", run);
            end
            for (int k = 0; k < 11; k++) begin
                idx = f + 7 + 16 * k;
                got = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
                compared++;
                if (got !== ((k < 10) ? exp_bits[k] : 1'b1)) begin
                    mismatched++;
                    $display("[TB] FAIL tx_bit%0d: got %b expected %b", k, got,
                             (k < 10) ? exp_bits[k] : 1'b1);
                end
            end
        end
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h60) begin
            mismatched++;
            $display("[TB] FAIL tx_txc_set: got %h expected 60", d);
        end
        bus_write(A_UCSRA, 8'h40);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h20) begin
            mismatched++;
            $display("[TB] FAIL tx_txc_clear: got %h expected 20", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d;
        logic        h;
        logic [21:0] exp_bits;
        int          f;
        int          idx;
        logic        got;
        exp_bits = {2'b11, 1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0};
        tx_log.delete();
        logging = 1'b1;
        bus_write(A_UDR, 8'h01);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h20) begin
            mismatched++;
            $display("[TB] FAIL b2b_udre_free: got %h expected 20", d);
        end
        bus_write(A_UDR, 8'h80);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL b2b_udre_full: got %h expected 00", d);
        end
        bus_write(A_UDR, 8'h55);
        repeat (420) @(negedge clk);
        logging = 1'b0;
        f = -1;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (f < 0 && tx_log[i] === 1'b0) f = i;
        end
        compared++;
        if (f < 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_start_seen: got none expected start bit");
        end else begin
            for (int k = 0; k < 22; k++) begin
                idx = f + 7 + 16 * k;
                got = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
                compared++;
                if (got !== exp_bits[k]) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_bit%0d: got %b expected %b", k, got, exp_bits[k]);
                end
            end
        end
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h60) begin
            mismatched++;
            $display("[TB] FAIL b2b_txc: got %h expected 60", d);
        end
        bus_write(A_UCSRA, 8'h40);
    endtask

    task automatic test_irq();
        bus_write(A_UCSRA, 8'h01);
        compared++;
        if (irq !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL irq_udre: got %b expected 1", irq);
        end
        bus_write(A_UCSRA, 8'h00);
        compared++;
        if (irq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL irq_disabled: got %b expected 0", irq);
        end
    endtask

    task automatic test_rx();
        logic [7:0] d;
        logic       h;
        bus_write(A_UBRR, 8'h03);
        bus_write(A_UCSRA, 8'h02);
        send_rx_frame(8'h3C, 1'b1);
        compared++;
        if (irq !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rx_irq: got %b expected 1", irq);
        end
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'hA2) begin
            mismatched++;
            $display("[TB] FAIL rx_status: got %h expected a2", d);
        end
        bus_read(A_UDR, d, h);
        compared++;
        if (d !== 8'h3C || h !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rx_data: got %h hit=%b expected 3c hit=1", d, h);
        end
        compared++;
        if (irq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rx_irq_clear: got %b expected 0", irq);
        end
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h22) begin
            mismatched++;
            $display("[TB] FAIL rx_rxc_clear: got %h expected 22", d);
        end
        bus_write(A_UCSRA, 8'h00);
    endtask

    task automatic test_rx_errors();
        logic [7:0] d;
        logic       h;
        send_rx_frame(8'h5A, 1'b0);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'hB0) begin
            mismatched++;
            $display("[TB] FAIL fe_status: got %h expected b0", d);
        end
        bus_read(A_UDR, d, h);
        compared++;
        if (d !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL fe_data: got %h expected 5a", d);
        end
        send_rx_frame(8'h11, 1'b1);
        send_rx_frame(8'h22, 1'b1);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'hA8) begin
            mismatched++;
            $display("[TB] FAIL dor_status: got %h expected a8", d);
        end
        bus_read(A_UDR, d, h);
        compared++;
        if (d !== 8'h11) begin
            mismatched++;
            $display("[TB] FAIL dor_data: got %h expected 11", d);
        end
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h20) begin
            mismatched++;
            $display("[TB] FAIL dor_clear: got %h expected 20", d);
        end
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h20) begin
            mismatched++;
            $display("[TB] FAIL glitch_ignored: got %h expected 20", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic       h;
        bus_write(A_UDR, 8'h00);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        compared++;
        if (tx !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midframe_tx_busy: got %b expected 0", tx);
        end
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        compared++;
        if (tx !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midframe_tx_idle: got %b expected 1", tx);
        end
        reset = 1'b1;
        bus_write(A_UBRR, 8'h03);
        repeat (200) @(negedge clk);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'h20) begin
            mismatched++;
            $display("[TB] FAIL midframe_status: got %h expected 20", d);
        end
        compared++;
        if (tx !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midframe_tx_stays_idle: got %b expected 1", tx);
        end
        send_rx_frame(8'hC3, 1'b1);
        bus_read(A_UCSRA, d, h);
        compared++;
        if (d !== 8'hA0) begin
            mismatched++;
            $display("[TB] FAIL midframe_rx_status: got %h expected a0", d);
        end
        bus_read(A_UDR, d, h);
        compared++;
        if (d !== 8'hC3) begin
            mismatched++;
            $display("[TB] FAIL midframe_rx_data: got %h expected c3", d);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        logging    = 1'b0;
        reset      = 1'b0;
        io_addr    = '0;
        io_wen     = 1'b0;
        io_ren     = 1'b0;
        io_wdata   = '0;
        rx         = 1'b1;
        $display("[TB] starting risc8_uart directed tests");
        test_reset();
        test_bus();
        test_tx();
        test_back_to_back();
        test_irq();
        test_rx();
        test_rx_errors();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
